mdc_delay_feeder: RTL and testbench
===================================

Name: mdc_delay_feeder

Overview:
- Front half of one radix-2 multipath-delay-commutator (MDC) stage in the FFT datapath; sits directly upstream of the complex 2x2 switch.
- Delays the lower path (x1) by DELAY valid samples and passes the upper path (x0) straight through.
- Generates the switch select, which toggles every DELAY valid samples, and registers all outputs so that data and sel reach the switch aligned.
- The post-switch DELAY on the upper output path is a separate downstream block.

Parameters:
- DELAY, 8, commutator delay depth in samples; power of two, 2..256.
- DW, 16, signed width of each real/imag component.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous frame restart; clears counters and primed state; delay contents are don't-care.
- in_valid  in  1  input sample pair valid; no backpressure.
- x0_re  in  DW  upper path real, signed.
- x0_im  in  DW  upper path imag, signed.
- x1_re  in  DW  lower path real, signed.
- x1_im  in  DW  lower path imag, signed.
- out_valid  out  1  output pair valid.
- sel  out  1  switch select, aligned with the output data.
- y0_re  out  DW  upper output real, to switch x0.
- y0_im  out  DW  upper output imag, to switch x0.
- y1_re  out  DW  delayed lower output real, to switch x1.
- y1_im  out  DW  delayed lower output imag, to switch x1.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, sel=0, all y outputs=0, sample counter=0, fill counter=0, delay line zeroed.
- Accept: a sample pair is accepted when in_valid=1 at a rising clk edge. Let k index accepted pairs from 0 since reset or clr.
- Delay line:
  - DELAY-entry shift register (or RAM ring buffer with a log2(DELAY) write/read pointer) on x1_re/x1_im.
  - Advances only on accepted pairs; holds otherwise, so input gaps of any length are tolerated.
- Output timing (latency 1 cycle from accept):
  - y0 = x0 of pair k.
  - y1 = x1 of pair k-DELAY.
  - sel = bit log2(DELAY) of k, i.e. (k/DELAY) mod 2.
  - Pattern with DELAY=4: k=0-3 sel=0, k=4-7 sel=1, k=8-11 sel=0, and so on.
- Sample counter: log2(DELAY)+1 bits, increments per accepted pair, wraps naturally. The wrap from all-ones to 0 toggles sel back to 0 with no glitch or extra cycle.
- Fill counter:
  - Saturates at DELAY.
  - primed = (fill == DELAY).
  - out_valid = registered (in_valid & primed), where primed is sampled before the current pair updates the counter.
  - The first DELAY accepted pairs after reset/clr therefore produce out_valid=0; the first out_valid=1 corresponds to k=DELAY, with sel=1.
- Idle: when in_valid=0, out_valid drops to 0 next cycle; y outputs and sel hold their last values.
- clr:
  - Next cycle, sample counter=0, fill=0, out_valid=0.
  - If clr and in_valid are both high in the same cycle, that pair is accepted as k=0 of the new frame: it is written into the delay line, and the counter becomes 1 and fill becomes 1.
- Reset mid-frame: asynchronous clear of all state; the next accepted pair is k=0.
- Arithmetic: none. Data is carried bit-exact, with no width growth or rounding.

Test Plan:
- Reset: hold rst_n=0 with random inputs and toggle rst_n low asynchronously mid-cycle -> all outputs 0 immediately; after release, the first out_valid appears only after 8 accepted pairs (DELAY=8).
- Continuous stream, DELAY=4, x0=k, x1=100+k, in_valid=1 for 16 cycles:
  - out_valid first high one cycle after accept k=4.
  - At k=4: y0=4, y1=100, sel=1.
  - At k=8: y0=8, y1=104, sel=0.
  - At k=12: sel=1.
- Gapped input: same stream with in_valid toggling 1,0,1,0 -> identical y/sel sequence on out_valid cycles as the continuous case; out_valid=0 and outputs held in gap cycles.
- Counter wrap: 40 continuous pairs with DELAY=4 -> sel sequence for k>=4 is 1111 0000 1111 ..., with exactly 4 samples per phase across each wrap.
- clr mid-frame:
  - Assert clr with in_valid=1 at k=6 -> that pair becomes new k=0.
  - out_valid stays low for 4 pairs, then resumes with sel=1 and y1 equal to x1 of the pair captured with clr.
- DELAY=2 and DELAY=256 parameter sweep with random data -> y1 matches a reference model delayed by DELAY accepted samples, and sel toggles every DELAY accepted samples.

Source files
------------

// File: rtl/mdc_delay_feeder.sv
`default_nettype none
// ============================================================================
// Module  : mdc_delay_feeder
// Purpose : Radix-2 MDC stage front end. Delays x1 by DELAY accepted samples,
//           passes x0 through and generates the aligned commutator select.
// Rev     : 1.0
// ============================================================================
module mdc_delay_feeder #(
  parameter int DELAY = 8,
  parameter int DW    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x0_re,
  input  logic signed [DW-1:0] x0_im,
  input  logic signed [DW-1:0] x1_re,
  input  logic signed [DW-1:0] x1_im,
  output logic                 out_valid,
  output logic                 sel,
  output logic signed [DW-1:0] y0_re,
  output logic signed [DW-1:0] y0_im,
  output logic signed [DW-1:0] y1_re,
  output logic signed [DW-1:0] y1_im
);

  localparam int            AW   = $clog2(DELAY);
  localparam logic [AW:0]   FULL = (AW+1)'(DELAY);

  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW:0]   k_w;
  logic [AW-1:0] ptr_w;
  logic          primed_w;

  logic [DW-1:0] mem_re_q [DELAY];
  logic [DW-1:0] mem_im_q [DELAY];

  logic          ov_q, sel_q;
  logic [DW-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;

  // A pair arriving together with clr is indexed as k=0 of the new frame.
  assign k_w      = clr ? '0 : cnt_q;
  assign ptr_w    = k_w[AW-1:0];
  assign primed_w = (fill_q == FULL) && !clr;

  always_comb begin
    cnt_d  = cnt_q;
    fill_d = fill_q;
    if (clr) begin
      cnt_d  = '0;
      fill_d = '0;
    end
    if (in_valid) begin
      cnt_d = k_w + 1'b1;
      if (fill_d != FULL) fill_d = fill_d + 1'b1;
    end
  end

  // Ring buffer indexed by the low counter bits: the slot read for pair k
  // still holds x1 of pair k-DELAY, and is then overwritten with pair k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fill_q  <= '0;
      ov_q    <= 1'b0;
      sel_q   <= 1'b0;
      y0_re_q <= '0;
      y0_im_q <= '0;
      y1_re_q <= '0;
      y1_im_q <= '0;
      for (int i = 0; i < DELAY; i++) begin
        mem_re_q[i] <= '0;
        mem_im_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
      ov_q   <= in_valid && primed_w;
      if (in_valid) begin
        sel_q           <= k_w[AW];
        y0_re_q         <= x0_re;
        y0_im_q         <= x0_im;
        y1_re_q         <= mem_re_q[ptr_w];
        y1_im_q         <= mem_im_q[ptr_w];
        mem_re_q[ptr_w] <= x1_re;
        mem_im_q[ptr_w] <= x1_im;
      end
    end
  end

  assign out_valid = ov_q;
  assign sel       = sel_q;
  assign y0_re     = y0_re_q;
  assign y0_im     = y0_im_q;
  assign y1_re     = y1_re_q;
  assign y1_im     = y1_im_q;

endmodule
`default_nettype wire

// File: tb/tb_mdc_delay_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdc_delay_feeder
// Purpose : Checks four DELAY variants against a sample-history model.
// Rev     : 1.0
// ============================================================================
module tb_mdc_delay_feeder;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int HL = 4096;

  function automatic int dly(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      2:       return 8;
      default: return 256;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst_n, clr, in_valid;
  logic [DW-1:0] x0_re, x0_im, x1_re, x1_im;

  logic          ov_a  [N];
  logic          sel_a [N];
  logic [DW-1:0] y0r_a [N];
  logic [DW-1:0] y0i_a [N];
  logic [DW-1:0] y1r_a [N];
  logic [DW-1:0] y1i_a [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    mdc_delay_feeder #(.DELAY(dly(gi)), .DW(DW)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (in_valid),
      .x0_re    (x0_re),
      .x0_im    (x0_im),
      .x1_re    (x1_re),
      .x1_im    (x1_im),
      .out_valid(ov_a[gi]),
      .sel      (sel_a[gi]),
      .y0_re    (y0r_a[gi]),
      .y0_im    (y0i_a[gi]),
      .y1_re    (y1r_a[gi]),
      .y1_im    (y1i_a[gi])
    );
  end

  // Model: accepted-pair history of the current frame, indexed by k.
  logic [DW-1:0] h1r [HL];
  logic [DW-1:0] h1i [HL];
  int            k;
  bit            fresh;
  bit            e_ov   [N];
  bit            e_sel  [N];
  bit            y1_kn  [N];
  logic [DW-1:0] e_y0r  [N];
  logic [DW-1:0] e_y0i  [N];
  logic [DW-1:0] e_y1r  [N];
  logic [DW-1:0] e_y1i  [N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s D=%0d actual=%0h required=%0h t=%0t", nm, dly(i), act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom());
  endfunction

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("out_valid", i, 64'(ov_a[i]),  64'(e_ov[i]));
      chk("sel",       i, 64'(sel_a[i]), 64'(e_sel[i]));
      chk("y0_re",     i, 64'(y0r_a[i]), 64'(e_y0r[i]));
      chk("y0_im",     i, 64'(y0i_a[i]), 64'(e_y0i[i]));
      if (y1_kn[i]) begin
        chk("y1_re", i, 64'(y1r_a[i]), 64'(e_y1r[i]));
        chk("y1_im", i, 64'(y1i_a[i]), 64'(e_y1i[i]));
      end
    end
  endtask

  task automatic step(input bit v, input bit c,
                      input logic [DW-1:0] a0r, input logic [DW-1:0] a0i,
                      input logic [DW-1:0] a1r, input logic [DW-1:0] a1i);
    int kk;
    in_valid = v; clr = c;
    x0_re = a0r; x0_im = a0i; x1_re = a1r; x1_im = a1i;
    @(posedge clk);
    #1;
    kk = c ? 0 : k;
    if (c) fresh = 1'b0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = dly(i);
      e_ov[i] = v && !c && (kk >= d);
      if (v) begin
        e_y0r[i] = a0r;
        e_y0i[i] = a0i;
        e_sel[i] = ((kk / d) % 2) == 1;
        if (kk >= d) begin
          e_y1r[i] = h1r[kk - d];
          e_y1i[i] = h1i[kk - d];
          y1_kn[i] = 1'b1;
        end else if (fresh) begin
          e_y1r[i] = '0;
          e_y1i[i] = '0;
          y1_kn[i] = 1'b1;
        end else begin
          y1_kn[i] = 1'b0;
        end
      end
    end
    if (v) begin
      h1r[kk] = a1r;
      h1i[kk] = a1i;
      k = kk + 1;
    end else begin
      k = kk;
    end
    check_all();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_out_valid", i, 64'(ov_a[i]),  64'd0);
      chk("rst_sel",       i, 64'(sel_a[i]), 64'd0);
      chk("rst_y0_re",     i, 64'(y0r_a[i]), 64'd0);
      chk("rst_y1_im",     i, 64'(y1i_a[i]), 64'd0);
    end
    repeat (3) begin
      in_valid = 1'($urandom()); clr = 1'($urandom());
      x0_re = rnd(); x0_im = rnd(); x1_re = rnd(); x1_im = rnd();
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
    fresh = 1'b1;
    for (int i = 0; i < N; i++) begin
      e_ov[i] = 1'b0; e_sel[i] = 1'b0; y1_kn[i] = 1'b1;
      e_y0r[i] = '0; e_y0i[i] = '0; e_y1r[i] = '0; e_y1i[i] = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    x0_re = '0; x0_im = '0; x1_re = '0; x1_im = '0;
    do_reset();

    // Continuous stream x0=k, x1=100+k with hand-computed pins.
    for (int j = 0; j < 16; j++) begin
      step(1'b1, 1'b0, DW'(j), rnd(), DW'(100 + j), rnd());
      if (j == 4) begin
        chk("k4_out_valid", 1, 64'(ov_a[1]),  64'd1);
        chk("k4_y0",        1, 64'(y0r_a[1]), 64'd4);
        chk("k4_y1",        1, 64'(y1r_a[1]), 64'd100);
        chk("k4_sel",       1, 64'(sel_a[1]), 64'd1);
      end
      if (j == 7) chk("k7_out_valid", 2, 64'(ov_a[2]), 64'd0);
      if (j == 8) begin
        chk("k8_out_valid", 2, 64'(ov_a[2]),  64'd1);
        chk("k8_y0",        1, 64'(y0r_a[1]), 64'd8);
        chk("k8_y1",        1, 64'(y1r_a[1]), 64'd104);
        chk("k8_sel",       1, 64'(sel_a[1]), 64'd0);
      end
      if (j == 12) chk("k12_sel", 1, 64'(sel_a[1]), 64'd1);
    end

    // Gapped stream after a frame restart.
    step(1'b0, 1'b1, rnd(), rnd(), rnd(), rnd());
    for (int j = 0; j < 32; j++)
      step(j % 2 == 0, 1'b0, DW'(j / 2), rnd(), DW'(100 + j / 2), rnd());

    // clr together with a valid pair at k=6.
    step(1'b0, 1'b1, rnd(), rnd(), rnd(), rnd());
    for (int j = 0; j < 6; j++)
      step(1'b1, 1'b0, DW'(j), rnd(), DW'(100 + j), rnd());
    step(1'b1, 1'b1, DW'(7), rnd(), DW'(555), rnd());
    for (int j = 1; j <= 4; j++) begin
      step(1'b1, 1'b0, rnd(), rnd(), rnd(), rnd());
      if (j == 3) chk("clr_k3_out_valid", 1, 64'(ov_a[1]), 64'd0);
    end
    chk("clr_k4_out_valid", 1, 64'(ov_a[1]),  64'd1);
    chk("clr_k4_sel",       1, 64'(sel_a[1]), 64'd1);
    chk("clr_k4_y1",        1, 64'(y1r_a[1]), 64'd555);

    // Randomized traffic with occasional clr and one mid-run async reset.
    for (int c = 0; c < 1500; c++) begin
      bit v, cl;
      if (c == 700) do_reset();
      v  = $urandom_range(0, 3) != 0;
      cl = $urandom_range(0, 299) == 0;
      step(v, cl, rnd(), rnd(), rnd(), rnd());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
